// File: rtl/quantize_multi.sv
// Multi-channel fixed-point requantizer: round half-up, saturate, optional ReLU.
// Two-stage valid/ready pipeline with a saturating debug counter of clipped vectors.
`timescale 1ns/1ps

module quantize_multi #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 8,
    parameter int CH       = 4,
    parameter int FRAC_IN  = 14,
    parameter int FRAC_OUT = 7,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    data_in,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   data_out,
    output logic [CH-1:0]         sat_flag,
    output logic [CNT_W-1:0]      sat_cnt,
    input  logic                  cnt_clr
);

    // SHIFT must be at least 1 so the rounding constant exists.
    localparam int SHIFT = FRAC_IN - FRAC_OUT;
    localparam int XW    = IN_W + 1;

    localparam logic signed [XW-1:0]    RND   = XW'(1) << (SHIFT - 1);
    localparam logic signed [XW-1:0]    MAX_R = XW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [XW-1:0]    MIN_R = -(XW'(1) << (OUT_W - 1));
    localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

    logic                 s1_valid;
    logic [CH*IN_W-1:0]   s1_data;
    logic                 s1_relu;
    logic                 s2_valid;
    logic                 en1;
    logic                 en2;

    logic [CH*OUT_W-1:0]  q_data;
    logic [CH-1:0]        q_sat;
    logic signed [IN_W-1:0]  x_in;
    logic signed [XW-1:0]    x_ext;
    logic signed [XW-1:0]    r;
    logic signed [OUT_W-1:0] y;
    logic                    sat;

    // Stage 2 frees when it is empty or draining; stage 1 frees when stage 2 can take its word.
    assign en2       = !s2_valid || out_ready;
    assign en1       = !s1_valid || en2;
    assign in_ready  = en1;
    assign out_valid = s2_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        q_data = '0;
        q_sat  = '0;
        x_in   = '0;
        x_ext  = '0;
        r      = '0;
        y      = '0;
        sat    = 1'b0;
        for (int k = 0; k < CH; k++) begin
            x_in  = s1_data[k*IN_W +: IN_W];
            x_ext = {x_in[IN_W-1], x_in};
            r     = (x_ext + RND) >>> SHIFT;
            if (r > MAX_R) begin
                y   = MAX_O;
                sat = 1'b1;
            end else if (r < MIN_R) begin
                y   = MIN_O;
                sat = 1'b1;
            end else begin
                y   = r[OUT_W-1:0];
                sat = 1'b0;
            end
            // A ReLU-zeroed result is not a clip, even if it first hit the negative rail.
            if (s1_relu && y[OUT_W-1]) begin
                y   = '0;
                sat = 1'b0;
            end
            q_data[k*OUT_W +: OUT_W] = y;
            q_sat[k]                 = sat;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_relu  <= 1'b0;
            s2_valid <= 1'b0;
            data_out <= '0;
            sat_flag <= '0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                s1_data  <= data_in;
                s1_relu  <= relu_en;
            end
            if (en2) begin
                s2_valid <= s1_valid;
                data_out <= q_data;
                sat_flag <= q_sat;
            end
        end
    end

    // Clear has priority over a coincident increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= '0;
        end else if (s2_valid && out_ready && (|sat_flag) && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule
